gecko_load_return: RTL and testbench
====================================

// Module: gecko_load_return
// PURPOSE
//  Load-return stage downstream of execute. Accepts one gecko_mem_operation_t per issued load and
//  pairs it, in order, with the data word returned by data memory. Emits a gecko_operation_t
//  writeback (sign/zero-extended, byte-aligned via gecko_get_load_operation) and a forwarded view.
//  Bounds loads in flight and backpressures execute when full.
// PARAMETERS
//  DEPTH  4  max loads in flight; power of 2, >=2
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst              in   1   synchronous, active-high reset
//  mem_op_valid     in   1   execute presents load metadata (same cycle the memory request issues)
//  mem_op_ready     out  1   slot available; execute issues a load only when high
//  mem_op           in   14  gecko_mem_operation_t {addr, reg_status, jump_flag, op, offset}
//  mem_resp_valid   in   1   memory read data valid; in order, latency >=1 cycle, no ready
//  mem_resp_data    in   32  raw 32-bit word read
//  wb_valid         out  1   writeback operation valid
//  wb_ready         in   1   writeback consumer accepts
//  wb_op            out  42  gecko_operation_t; speculative always 0
//  forward          out  43  gecko_forwarded_t of wb_op; valid == wb_valid
//  resp_error       out  1   sticky: response arrived with no outstanding load
// BEHAVIOUR
//  - Reset: alloc/fill/retire ptrs=0, count=0, all slot data_valid=0, wb_valid=0, resp_error=0;
//    mem_op_ready=1 in cycle after reset. Memory is reset by same rst; in-flight loads discarded.
//  - Ring of DEPTH slots: {mem_op, data, data_valid}. alloc ptr writes on mem_op_valid&&mem_op_ready;
//    fill ptr writes data, sets data_valid on mem_resp_valid; retire ptr frees on head handshake.
//  - count = allocated-not-retired (width $clog2(DEPTH)+1); mem_op_ready = (count != DEPTH).
//    No ready->valid or ready->ready combinational path from wb_ready.
//  - outstanding = alloc-fill distance; mem_resp_valid with outstanding==0 (measured before this
//    cycle's alloc) -> data dropped, resp_error set until rst. Memory latency >=1 makes this exact.
//  - Head presentable when slot[retire].data_valid. wb_op = gecko_get_load_operation(slot op, data).
//  - Alloc, fill and retire may all fire same cycle; count += alloc - retire. Full + retire same
//    cycle: mem_op_ready still 0 that cycle (registered count), 1 next.
//  - Pointers wrap modulo DEPTH; full/empty distinguished by count, not pointer equality.
//  - Latency (no macro): mem_resp_valid cycle N -> wb_valid cycle N+1 if slot is head.
//  - wb_op/forward held stable while wb_valid && !wb_ready.
//  - Extension: B sign-extends bit 7 of selected byte, H bit 15 of halfword at offset[1];
//    BU/HU zero-extend; W passes word unchanged (offset ignored).
// CONFIGURATION
//  GECKO_LOAD_RETURN_OUTPUT_REG_EN
//   defined: extra output register after extension; resp->wb_valid latency 2; register loads when
//     !wb_valid || wb_ready (full throughput, 1 load/cycle); forward driven from the register.
//   undefined: wb_op/forward combinational from head slot; latency 1 as above.
//  Both builds identical in ordering, backpressure and resp_error.
// STRUCTURE
//  - gecko package: add GECKO_LOAD_RETURN_DEPTH_DEFAULT=4; reuse gecko_mem_operation_t,
//    gecko_operation_t, gecko_forwarded_t, gecko_get_load_operation, gecko_construct_forward.
//  - One sub-module: gecko_load_slot_ring (DEPTH slots, three pointers, count); top adds
//    extension, optional output register and error flag.
// TESTING
//  1 LW addr=5 offset=0, resp 0xDEADBEEF 2 cycles later, wb_ready=1 -> wb_op.addr=5,
//    value=0xDEADBEEF, speculative=0; wb_valid exactly 1 cycle.
//  2 LB offset=3 resp 0x80000000 -> 0xFFFFFF80; LBU same -> 0x00000080; LH offset=2 resp
//    0x7FFF0000 -> 0x00007FFF; LHU offset=2 resp 0x80010000 -> 0x00008001.
//  3 Issue 4 loads with wb_ready=0 -> mem_op_ready=0 after 4th; 5th held; wb_ready=1 -> retire
//    in issue order, mem_op_ready=1 the cycle after first retire.
//  4 Back-to-back loads every cycle, resp latency 1, wb_ready=1 for 20 cycles -> 1 wb/cycle,
//    pointer wrap exercised, order preserved.
//  5 mem_resp_valid with nothing outstanding -> resp_error=1, no wb_valid; stays 1 until rst.
//  6 rst asserted with 3 loads in flight -> next cycle wb_valid=0, mem_op_ready=1, resp_error=0.

Source files
------------

// File: rtl/gecko_pkg.sv
// gecko_pkg: shared gecko types, load-return depth default and load extension helpers
package gecko_pkg;
  localparam int GECKO_LOAD_RETURN_DEPTH_DEFAULT = 4;
  typedef enum logic [2:0] {
    GECKO_LB  = 3'b000,
    GECKO_LH  = 3'b001,
    GECKO_LW  = 3'b010,
    GECKO_LBU = 3'b100,
    GECKO_LHU = 3'b101
  } gecko_load_op_e;
  typedef struct packed {
    logic [4:0]     addr;
    logic [2:0]     reg_status;
    logic           jump_flag;
    gecko_load_op_e op;
    logic [1:0]     offset;
  } gecko_mem_operation_t;
  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic [2:0]  reg_status;
    logic        jump_flag;
    logic        speculative;
  } gecko_operation_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [4:0]  addr;
    logic [2:0]  reg_status;
    logic        jump_flag;
    logic        speculative;
  } gecko_forwarded_t;
  function automatic gecko_operation_t gecko_get_load_operation(gecko_mem_operation_t m, logic [31:0] d);
    gecko_operation_t r;
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{m.offset, 3'b000} +: 8];
    h = m.offset[1] ? d[31:16] : d[15:0];
    r.value = m.op == GECKO_LB  ? {{24{b[7]}}, b} :
              m.op == GECKO_LBU ? {24'b0, b} :
              m.op == GECKO_LH  ? {{16{h[15]}}, h} :
              m.op == GECKO_LHU ? {16'b0, h} : d;
    r.addr = m.addr;
    r.reg_status = m.reg_status;
    r.jump_flag = m.jump_flag;
    r.speculative = 1'b0;
    return r;
  endfunction
  function automatic gecko_forwarded_t gecko_construct_forward(gecko_operation_t o, logic v);
    return '{valid: v, value: o.value, addr: o.addr, reg_status: o.reg_status,
             jump_flag: o.jump_flag, speculative: o.speculative};
  endfunction
endpackage

// File: rtl/gecko_load_return_if.sv
// gecko_load_return_if: load metadata, memory response and writeback signals of the load-return stage
interface gecko_load_return_if;
  import gecko_pkg::*;
  logic                 mem_op_valid;
  logic                 mem_op_ready;
  gecko_mem_operation_t mem_op;
  logic                 mem_resp_valid;
  logic [31:0]          mem_resp_data;
  logic                 wb_valid;
  logic                 wb_ready;
  gecko_operation_t     wb_op;
  gecko_forwarded_t     forward;
  logic                 resp_error;
  modport slave (
    input  mem_op_valid, mem_op, mem_resp_valid, mem_resp_data, wb_ready,
    output mem_op_ready, wb_valid, wb_op, forward, resp_error
  );
  modport master (
    output mem_op_valid, mem_op, mem_resp_valid, mem_resp_data, wb_ready,
    input  mem_op_ready, wb_valid, wb_op, forward, resp_error
  );
endinterface

// File: rtl/gecko_load_slot_ring.sv
// gecko_load_slot_ring: in-order ring of load slots with alloc/fill/retire pointers and occupancy count
module gecko_load_slot_ring
  import gecko_pkg::*;
#(
  parameter int DEPTH = GECKO_LOAD_RETURN_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  gecko_mem_operation_t alloc_op,
  input  logic                 fill,
  input  logic [31:0]          fill_data,
  input  logic                 retire,
  output logic                 ready,
  output logic                 pending,
  output logic                 head_valid,
  output gecko_mem_operation_t head_op,
  output logic [31:0]          head_data
);
  localparam int PW = $clog2(DEPTH);
  gecko_mem_operation_t op_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [DEPTH-1:0] dv_q;
  logic [PW-1:0] a_ptr, f_ptr, r_ptr;
  logic [PW:0] count, unfilled;
  // Pointers, occupancy and per-slot data-valid flags; unfilled tracks loads still awaiting data
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ptr <= '0;
      f_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      unfilled <= '0;
      dv_q <= '0;
    end else begin
      if (alloc) a_ptr <= a_ptr + 1'b1;
      if (fill) begin
        dv_q[f_ptr] <= 1'b1;
        f_ptr <= f_ptr + 1'b1;
      end
      if (retire) begin
        dv_q[r_ptr] <= 1'b0;
        r_ptr <= r_ptr + 1'b1;
      end
      count <= count + (PW+1)'(alloc) - (PW+1)'(retire);
      unfilled <= unfilled + (PW+1)'(alloc) - (PW+1)'(fill);
    end
  end
  // Slot payload storage needs no reset; data_valid guards every read
  always_ff @(posedge clk) begin
    if (alloc) op_q[a_ptr] <= alloc_op;
    if (fill) data_q[f_ptr] <= fill_data;
  end
  assign ready = count != (PW+1)'(DEPTH);
  assign pending = unfilled != '0;
  assign head_valid = dv_q[r_ptr];
  assign head_op = op_q[r_ptr];
  assign head_data = data_q[r_ptr];
endmodule

// File: rtl/gecko_load_return.sv
// gecko_load_return: pairs load metadata with memory data in order and emits writeback; GECKO_LOAD_RETURN_OUTPUT_REG_EN adds an output register
module gecko_load_return
  import gecko_pkg::*;
#(
  parameter int DEPTH = GECKO_LOAD_RETURN_DEPTH_DEFAULT
) (
  input logic clk,
  input logic rst,
  gecko_load_return_if.slave bus
);
  logic alloc, fill, retire, pending, head_valid;
  gecko_mem_operation_t head_op;
  logic [31:0] head_data;
  gecko_operation_t ext_op;
  assign alloc = bus.mem_op_valid && bus.mem_op_ready;
  assign fill = bus.mem_resp_valid && pending;
  assign ext_op = gecko_get_load_operation(head_op, head_data);
  gecko_load_slot_ring #(.DEPTH(DEPTH)) ring (
    .clk(clk),
    .rst(rst),
    .alloc(alloc),
    .alloc_op(bus.mem_op),
    .fill(fill),
    .fill_data(bus.mem_resp_data),
    .retire(retire),
    .ready(bus.mem_op_ready),
    .pending(pending),
    .head_valid(head_valid),
    .head_op(head_op),
    .head_data(head_data)
  );
`ifdef GECKO_LOAD_RETURN_OUTPUT_REG_EN
  gecko_operation_t out_q;
  logic out_v;
  assign retire = head_valid && (!out_v || bus.wb_ready);
  // Output valid refills whenever the register is empty or being drained
  always_ff @(posedge clk) begin
    if (rst) out_v <= 1'b0;
    else if (!out_v || bus.wb_ready) out_v <= head_valid;
  end
  // Extended result captured as the head slot retires into the register
  always_ff @(posedge clk) begin
    if (retire) out_q <= ext_op;
  end
  assign bus.wb_valid = out_v;
  assign bus.wb_op = out_q;
`else
  assign retire = head_valid && bus.wb_ready;
  assign bus.wb_valid = head_valid;
  assign bus.wb_op = ext_op;
`endif
  assign bus.forward = gecko_construct_forward(bus.wb_op, bus.wb_valid);
  // Sticky flag for a response that has no outstanding load to pair with
  always_ff @(posedge clk) begin
    if (rst) bus.resp_error <= 1'b0;
    else if (bus.mem_resp_valid && !pending) bus.resp_error <= 1'b1;
  end
endmodule

// File: tb/tb_gecko_load_return.sv
// tb_gecko_load_return: directed stimulus with a scoreboard queue checked by a writeback monitor
module tb_gecko_load_return;
  import gecko_pkg::*;
  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int wb_seen = 0;
  exp_t sbq[$];
  gecko_load_return_if bus();
  gecko_load_return dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Monitor: every writeback handshake pops the oldest expected load
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.wb_valid && bus.wb_ready) begin
      wb_seen++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got value=%h addr=%0d required no writeback", bus.wb_op.value, bus.wb_op.addr);
      end else begin
        e = sbq.pop_front();
        if (bus.wb_op.value !== e.value || bus.wb_op.addr !== e.addr || bus.wb_op.speculative !== 1'b0 ||
            bus.forward.valid !== 1'b1 || bus.forward.value !== e.value || bus.forward.addr !== e.addr) begin
          failures++;
          $display("FAIL wb_op got value=%h addr=%0d spec=%b fwd_v=%b fwd_value=%h required value=%h addr=%0d spec=0 fwd_v=1",
                   bus.wb_op.value, bus.wb_op.addr, bus.wb_op.speculative, bus.forward.valid, bus.forward.value, e.value, e.addr);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, expv);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input gecko_load_op_e op, input logic [4:0] a, input logic [1:0] off, input logic [31:0] expv);
    int n = 0;
    bus.mem_op = '{addr: a, reg_status: 3'd0, jump_flag: 1'b0, op: op, offset: off};
    bus.mem_op_valid = 1'b1;
    while (!bus.mem_op_ready && n < 50) begin
      tick();
      n++;
    end
    chk("issue_ready", 32'(bus.mem_op_ready), 32'd1);
    sbq.push_back('{expv, a});
    tick();
    bus.mem_op_valid = 1'b0;
  endtask
  task automatic resp(input logic [31:0] d);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = d;
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    gecko_load_op_e ops [4] = '{GECKO_LB, GECKO_LBU, GECKO_LH, GECKO_LHU};
    logic [1:0] offs [4] = '{2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] datas [4] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h8001_0000};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7FFF, 32'h0000_8001};
    int base;
    rst = 1'b1;
    bus.mem_op_valid = 1'b0;
    bus.mem_op = '0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    bus.wb_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_ready", 32'(bus.mem_op_ready), 32'd1);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset_resp_error", 32'(bus.resp_error), 32'd0);
    issue(GECKO_LW, 5'd5, 2'd0, 32'hDEAD_BEEF);
    tick();
    resp(32'hDEAD_BEEF);
    chk("lw_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lw_speculative", 32'(bus.wb_op.speculative), 32'd0);
    tick();
    chk("lw_wb_one_cycle", 32'(bus.wb_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], 5'(k + 1), offs[k], exps[k]);
      resp(datas[k]);
      tick();
    end
    bus.wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(GECKO_LW, 5'(10 + k), 2'd0, 32'hA0 + 32'(k));
    chk("full_ready_low", 32'(bus.mem_op_ready), 32'd0);
    for (int k = 0; k < 4; k++) resp(32'hA0 + 32'(k));
    bus.mem_op = '{addr: 5'd14, reg_status: 3'd0, jump_flag: 1'b0, op: GECKO_LW, offset: 2'd0};
    bus.mem_op_valid = 1'b1;
    tick();
    tick();
    chk("fifth_held", 32'(bus.mem_op_ready), 32'd0);
    chk("full_wb_valid", 32'(bus.wb_valid), 32'd1);
    bus.wb_ready = 1'b1;
    chk("retire_cycle_ready_low", 32'(bus.mem_op_ready), 32'd0);
    tick();
    chk("after_retire_ready", 32'(bus.mem_op_ready), 32'd1);
    sbq.push_back('{32'hA4, 5'd14});
    tick();
    bus.mem_op_valid = 1'b0;
    tick();
    tick();
    resp(32'hA4);
    tick();
    base = wb_seen;
    for (int i = 0; i < 22; i++) begin
      bus.mem_op_valid = i < 20;
      if (i < 20) begin
        bus.mem_op = '{addr: 5'(i), reg_status: 3'd0, jump_flag: 1'b0, op: GECKO_LW, offset: 2'd0};
        chk("b2b_ready", 32'(bus.mem_op_ready), 32'd1);
        sbq.push_back('{32'h1000_0000 + 32'(i), 5'(i)});
      end
      bus.mem_resp_valid = i >= 1 && i <= 20;
      bus.mem_resp_data = 32'h1000_0000 + 32'(i) - 32'd1;
      if (i >= 2) chk("b2b_wb_valid", 32'(bus.wb_valid), 32'd1);
      tick();
    end
    bus.mem_op_valid = 1'b0;
    bus.mem_resp_valid = 1'b0;
    chk("b2b_wb_count", 32'(wb_seen - base), 32'd20);
    tick();
    chk("idle_resp_error", 32'(bus.resp_error), 32'd0);
    resp(32'h1234_5678);
    chk("stray_resp_error", 32'(bus.resp_error), 32'd1);
    chk("stray_no_wb", 32'(bus.wb_valid), 32'd0);
    repeat (3) tick();
    chk("resp_error_sticky", 32'(bus.resp_error), 32'd1);
    for (int k = 0; k < 3; k++) issue(GECKO_LW, 5'(20 + k), 2'd0, 32'h0);
    rst = 1'b1;
    sbq.delete();
    tick();
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_ready", 32'(bus.mem_op_ready), 32'd1);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    rst = 1'b0;
    issue(GECKO_LW, 5'd7, 2'd0, 32'hCAFE_F00D);
    resp(32'hCAFE_F00D);
    tick();
    tick();
    chk("post_rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
